// File: rtl/reg_scoreboard.sv
// Per-GPR pending-writer scoreboard gating dual-lane issue against RAW hazards and counter overflow.
// Optional build macro SCB_WB_BYPASS_EN lets a same-cycle write-back release a RAW hazard.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic [1:0]      iss_valid_i,
  input  logic [1:0]      iss_we_i,
  input  logic [2*AW-1:0] iss_dest_i,
  input  logic [3:0]      iss_rs_en_i,
  input  logic [4*AW-1:0] iss_rs_i,
  output logic [1:0]      iss_ready_o,
  input  logic [1:0]      wb_we_i,
  input  logic [2*AW-1:0] wb_dest_i,
  output logic            empty_o,
  output logic            err_o
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             err_q, err_d;

  logic [AW-1:0] dest [2];
  logic [AW-1:0] wbDest [2];
  logic [AW-1:0] src [4];
  logic [3:0]    srcHz;
  logic          sameDest, lane1Sat, raw1, ready0, ready1;
  logic [1:0]    fire;

  function automatic logic [1:0] wbHits(input logic [AW-1:0] a, input logic [1:0] we,
                                        input logic [AW-1:0] d0, input logic [AW-1:0] d1);
    wbHits = {1'b0, (we[0] && (d0 == a))} + {1'b0, (we[1] && (d1 == a))};
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      dest[k]   = iss_dest_i[k*AW +: AW];
      wbDest[k] = wb_dest_i[k*AW +: AW];
    end
    for (int s = 0; s < 4; s++) src[s] = iss_rs_i[s*AW +: AW];
  end

  // With bypass, a source whose remaining writers all retire this cycle is free to read.
  always_comb begin
    srcHz = '0;
    for (int s = 0; s < 4; s++) begin
`ifdef SCB_WB_BYPASS_EN
      srcHz[s] = iss_rs_en_i[s] && (src[s] != '0) &&
                 ({2'b00, cnt_q[src[s]]} >
                  {{CNT_W{1'b0}}, wbHits(src[s], wb_we_i, wbDest[0], wbDest[1])});
`else
      srcHz[s] = iss_rs_en_i[s] && (src[s] != '0) && (cnt_q[src[s]] != '0);
`endif
    end
  end

  always_comb begin
    sameDest = iss_we_i[0] && (dest[0] == dest[1]);
    lane1Sat = iss_we_i[1] && (dest[1] != '0) &&
               (({1'b0, cnt_q[dest[1]]} + {{CNT_W{1'b0}}, sameDest}) >= {1'b0, CMAX});
    raw1     = iss_we_i[0] && (dest[0] != '0) &&
               ((iss_rs_en_i[2] && (src[2] == dest[0])) || (iss_rs_en_i[3] && (src[3] == dest[0])));
    ready0   = !flush_i && !srcHz[0] && !srcHz[1] &&
               !(iss_we_i[0] && (dest[0] != '0) && (cnt_q[dest[0]] == CMAX));
    ready1   = ready0 && iss_valid_i[0] && !srcHz[2] && !srcHz[3] && !raw1 && !lane1Sat;
    iss_ready_o = {ready1, ready0};
    fire        = iss_valid_i & {ready1, ready0};
  end

  // Issue and write-back are netted per register; a flush wipes everything and masks underflow.
  always_comb begin : upd
    logic [1:0]       inc;
    logic [1:0]       dec;
    logic [CNT_W+1:0] sum;
    err_d = err_q;
    inc   = '0;
    dec   = '0;
    sum   = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = '0;
      if (!flush_i && (r != 0)) begin
        inc = {1'b0, (fire[0] && iss_we_i[0] && (dest[0] == AW'(r)))} +
              {1'b0, (fire[1] && iss_we_i[1] && (dest[1] == AW'(r)))};
        dec = wbHits(AW'(r), wb_we_i, wbDest[0], wbDest[1]);
        sum = {2'b00, cnt_q[r]} + {{CNT_W{1'b0}}, inc};
        if ({{CNT_W{1'b0}}, dec} > sum) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = CNT_W'(sum - {{CNT_W{1'b0}}, dec});
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end

  always_comb begin
    empty_o = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      if (cnt_q[r] != '0) empty_o = 1'b0;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed vectors push expected outputs, a negedge monitor pops and compares.
module tb_reg_scoreboard;
  localparam int AW = 5;

  logic            clock = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [1:0]      issValid, issWe, issReady, wbWe;
  logic [2*AW-1:0] issDest, wbDest;
  logic [3:0]      issRsEn;
  logic [4*AW-1:0] issRs;
  logic            empty, err;

  int cycleCount = 0;
  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] ready;
    logic       empty;
    logic       err;
  } expT;
  expT expQ[$];

`ifdef SCB_WB_BYPASS_EN
  localparam logic [1:0] WB_CYCLE_READY = 2'b11;
`else
  localparam logic [1:0] WB_CYCLE_READY = 2'b00;
`endif

  reg_scoreboard #(.NREG(32), .AW(AW), .CNT_W(2)) dut (
    .clk(clock), .rst_n(rst_n), .flush_i(flush),
    .iss_valid_i(issValid), .iss_we_i(issWe), .iss_dest_i(issDest),
    .iss_rs_en_i(issRsEn), .iss_rs_i(issRs), .iss_ready_o(issReady),
    .wb_we_i(wbWe), .wb_dest_i(wbDest), .empty_o(empty), .err_o(err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input string field,
                             input logic [1:0] act, input logic [1:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s.%s actual=%b expected=%b", name, field, act, exp);
  endtask

  task automatic applyStimulus(input string name, input logic [1:0] valid, input logic [1:0] we,
                               input logic [AW-1:0] d1, input logic [AW-1:0] d0, input logic [3:0] rsEn,
                               input logic [AW-1:0] s3, input logic [AW-1:0] s2,
                               input logic [AW-1:0] s1, input logic [AW-1:0] s0,
                               input logic [1:0] wbe, input logic [AW-1:0] w1, input logic [AW-1:0] w0,
                               input logic fl, input logic [1:0] eRdy, input logic eEmp, input logic eErr);
    expT e;
    @(posedge clock);
    #1;
    issValid = valid; issWe = we; issDest = {d1, d0};
    issRsEn  = rsEn;  issRs = {s3, s2, s1, s0};
    wbWe     = wbe;   wbDest = {w1, w0};
    flush    = fl;
    e.cyc = cycleCount; e.name = name; e.ready = eRdy; e.empty = eEmp; e.err = eErr;
    expQ.push_back(e);
  endtask

  // Monitor: each negedge, compare every expectation tagged for the current cycle.
  always @(negedge clock) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cycleCount) begin
      expT e;
      e = expQ.pop_front();
      checkOutput(e.name, "ready", issReady, e.ready);
      checkOutput(e.name, "empty", {1'b0, empty}, {1'b0, e.empty});
      checkOutput(e.name, "err",   {1'b0, err},   {1'b0, e.err});
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; issValid = '0; issWe = '0; issDest = '0;
    issRsEn = '0; issRs = '0; wbWe = '0; wbDest = '0;
    #12 rst_n = 1'b1;
    //             name        vld   we     d1  d0  rsen     s3  s2  s1  s0  wbwe  w1  w0 fl  rdy    emp  err
    applyStimulus("idle",      2'b00, 2'b00, 0,  0, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b01, 1'b1, 1'b0);
    applyStimulus("rstReady",  2'b11, 2'b00, 0,  0, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b11, 1'b1, 1'b0);
    applyStimulus("iss5",      2'b01, 2'b01, 0,  5, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b11, 1'b1, 1'b0);
    applyStimulus("raw5",      2'b01, 2'b00, 0,  0, 4'b0001, 0,  0,  0,  5, 2'b00, 0,  0, 0, 2'b00, 1'b0, 1'b0);
    applyStimulus("raw5wb",    2'b01, 2'b00, 0,  0, 4'b0001, 0,  0,  0,  5, 2'b01, 0,  5, 0, WB_CYCLE_READY, 1'b0, 1'b0);
    applyStimulus("rel5",      2'b01, 2'b00, 0,  0, 4'b0001, 0,  0,  0,  5, 2'b00, 0,  0, 0, 2'b11, 1'b1, 1'b0);
    applyStimulus("pair7",     2'b11, 2'b01, 0,  7, 4'b0100, 0,  7,  0,  0, 2'b00, 0,  0, 0, 2'b01, 1'b1, 1'b0);
    applyStimulus("wb7",       2'b00, 2'b00, 0,  0, 4'b0000, 0,  0,  0,  0, 2'b01, 0,  7, 0, 2'b01, 1'b0, 1'b0);
    applyStimulus("iss3",      2'b01, 2'b01, 0,  3, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b11, 1'b1, 1'b0);
    applyStimulus("dual3",     2'b11, 2'b11, 3,  3, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b11, 1'b0, 1'b0);
    applyStimulus("sat0",      2'b01, 2'b01, 0,  3, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b00, 1'b0, 1'b0);
    applyStimulus("sat1",      2'b11, 2'b10, 3,  0, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b01, 1'b0, 1'b0);
    applyStimulus("wb3a",      2'b00, 2'b00, 0,  0, 4'b0000, 0,  0,  0,  0, 2'b01, 0,  3, 0, 2'b01, 1'b0, 1'b0);
    applyStimulus("net3",      2'b01, 2'b01, 0,  3, 4'b0000, 0,  0,  0,  0, 2'b11, 3,  3, 0, 2'b11, 1'b0, 1'b0);
    applyStimulus("probe3",    2'b11, 2'b11, 3,  3, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b11, 1'b0, 1'b0);
    applyStimulus("wb3dual",   2'b00, 2'b00, 0,  0, 4'b0000, 0,  0,  0,  0, 2'b11, 3,  3, 0, 2'b01, 1'b0, 1'b0);
    applyStimulus("wb3last",   2'b00, 2'b00, 0,  0, 4'b0000, 0,  0,  0,  0, 2'b01, 0,  3, 0, 2'b01, 1'b0, 1'b0);
    applyStimulus("drained",   2'b11, 2'b00, 0,  0, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b11, 1'b1, 1'b0);
    applyStimulus("zeroA",     2'b11, 2'b11, 0,  0, 4'b1111, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b11, 1'b1, 1'b0);
    applyStimulus("zeroB",     2'b11, 2'b11, 0,  0, 4'b1111, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b11, 1'b1, 1'b0);
    applyStimulus("iss1_9",    2'b11, 2'b11, 9,  1, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b11, 1'b1, 1'b0);
    applyStimulus("iss31",     2'b01, 2'b01, 0, 31, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b11, 1'b0, 1'b0);
    applyStimulus("flush",     2'b01, 2'b01, 0,  9, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 1, 2'b00, 1'b0, 1'b0);
    applyStimulus("postFlush", 2'b11, 2'b00, 0,  0, 4'b0111, 0, 31,  1,  9, 2'b00, 0,  0, 0, 2'b11, 1'b1, 1'b0);
    applyStimulus("staleWb9",  2'b00, 2'b00, 0,  0, 4'b0000, 0,  0,  0,  0, 2'b01, 0,  9, 0, 2'b01, 1'b1, 1'b0);
    applyStimulus("errSet",    2'b00, 2'b00, 0,  0, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b01, 1'b1, 1'b1);
    applyStimulus("errStick",  2'b11, 2'b00, 0,  0, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b11, 1'b1, 1'b1);
    applyStimulus("iss12",     2'b01, 2'b01, 0, 12, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b11, 1'b1, 1'b1);
    applyStimulus("pend12",    2'b00, 2'b00, 0,  0, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b01, 1'b0, 1'b1);
    // Reset drops mid-cycle; the negedge check lands before any further clock edge.
    applyStimulus("asyncRst",  2'b00, 2'b00, 0,  0, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b01, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3 rst_n = 1'b1;
    applyStimulus("postRst",   2'b11, 2'b00, 0,  0, 4'b0000, 0,  0,  0,  0, 2'b00, 0,  0, 0, 2'b11, 1'b1, 1'b0);
    applyStimulus("free12",    2'b01, 2'b00, 0,  0, 4'b0001, 0,  0,  0, 12, 2'b00, 0,  0, 0, 2'b11, 1'b1, 1'b0);
    @(negedge clock);
    @(negedge clock);
    checkCount++;
    if (expQ.size() == 0) passCount++;
    else $display("[TB] FAIL queueDrain actual=%0d expected=0", expQ.size());
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight GPR writes between the dual-issue ID stage and the register-file/CSR box.
- Keeps a per-register pending-writer counter, incremented at issue and decremented at register write-back.
- Drives per-lane issue-ready so ID never reads a GPR that still has a write in flight (RAW) and never overflows a counter.
- Provides an all-clear flag so ID can serialize CSR, ertn and barrier instructions.

Parameters:
- NREG, 32, number of GPRs; r0 is never tracked.
- AW, 5, register address width.
- CNT_W, 2, pending counter width; max outstanding writers per register = 2^CNT_W-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush (exception, ertn, branch mispredict beyond ID)
- iss_valid_i  in  2  per-lane issue request from ID
- iss_we_i  in  2  lane writes a GPR
- iss_dest_i  in  2*AW  {lane1,lane0} destination address
- iss_rs_en_i  in  4  source read enables {l1s1,l1s0,l0s1,l0s0}
- iss_rs_i  in  4*AW  source addresses, same order
- iss_ready_o  out  2  per-lane ready; lane k fires = iss_valid_i[k] & iss_ready_o[k]
- wb_we_i  in  2  write-back lane register write enable, same cycle as the register-file write
- wb_dest_i  in  2*AW  write-back addresses
- empty_o  out  1  all counters zero (registered state)
- err_o  out  1  sticky underflow error

Behaviour:
- State is cnt[1..NREG-1], CNT_W bits each. Reset: all cnt 0, err_o 0. Combinational outputs reset to iss_ready_o=2'b11 and empty_o=1.
- Address 0 in any field: never hazards, never counted.
- hazard(src) = rs_en & (rs != 0) & (cnt[rs] != 0), evaluated on registered cnt. Write-back in the same cycle is not seen; see Optional Feature.
- iss_ready_o[0] = !flush_i & no hazard on lane0 sources & !(iss_we_i[0] & cnt[dest0] == MAX).
- iss_ready_o[1] = iss_ready_o[0] & iss_valid_i[0] & no hazard on lane1 sources & no intra-pair dependency & lane1 saturation check.
  - Intra-pair dependency: lane1 enabled source equals lane0 dest, lane0 we=1, dest0 != 0.
  - Saturation check: cnt[dest1] + (lane0 fires to the same dest ? 1 : 0) < MAX.
  - Lane1 never issues without lane0, which keeps issue in order.
- Update on clk rising edge, per register r: cnt_next = cnt + inc(r) - dec(r).
  - inc(r): number of firing lanes with we=1 and dest=r, range 0..2.
  - dec(r): number of wb lanes with we=1 and dest=r, range 0..2.
  - Simultaneous inc and dec on the same register are netted.
- Underflow (dec > cnt + inc): cnt_next = 0 and err_o is set. err_o clears only on reset.
- flush_i: all cnt cleared to 0 at the next edge. Priority over issue and write-back in the same cycle. iss_ready_o forced 0 during the flush cycle. A write-back arriving after a flush decrements a 0 counter and sets err_o. The pipeline must squash write-backs of flushed instructions.
- empty_o = all cnt == 0, combinational from registered state. A CSR instruction issues only when empty_o=1; the gating is done by ID.
- Latency: counter visible one cycle after fire. Hazard release is one cycle after the write-back cycle, which matches the synchronous register-file write.
- Reset mid-operation: asynchronous clear of all state regardless of pending issue or write-back.

Optional Feature:
- Macro: SCB_WB_BYPASS_EN
- Defined: hazard uses the effective count cnt[rs] - dec(rs) from the current-cycle write-back, so a source whose last writer is retiring this cycle is not a hazard. ID must forward wb data for that case. Release latency drops to 0 cycles.
- Undefined: hazard uses the registered cnt only, as specified above.

Test Plan:
- Reset, then lane0 issue we=1 dest=5 -> next cycle cnt[5]=1, empty_o=0. Lane0 source rs=5 -> iss_ready_o=2'b00. wb dest=5 -> cnt[5]=0 one cycle later and ready=2'b11 the cycle after that; with SCB_WB_BYPASS_EN, ready=1 in the wb cycle.
- Dual issue with lane0 dest=7 and lane1 source=7 -> iss_ready_o=2'b01; only lane0 fires, cnt[7]=1.
- Both lanes dest=3 fire with CNT_W=2 from cnt[3]=1 -> cnt[3]=3. Next lane0 dest=3 -> ready0=0. Two wb lanes dest=3 plus one issue dest=3 in the same cycle -> cnt[3]=2.
- Dest 0 and sources 0 on both lanes -> always ready, counters unchanged, empty_o stays 1.
- Pending counts on r1, r9, r31; assert flush_i together with an issue dest=9 -> ready=00, all cnt=0 next cycle, empty_o=1. Then wb dest=9 -> err_o=1 and stays 1.
- Assert rst_n=0 asynchronously mid-cycle with counts pending -> all cnt=0, err_o=0 immediately, without waiting for a clock edge.
